int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 149 ++++++++++++++
 tb/tb_int_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl - four-line vectored interrupt controller
//
// Captures rising edges on four raw interrupt lines into pending bits. It
// selects the lowest-index pending line that is enabled by the mask. It then
// requests service from the control unit with a fixed handler vector of
// VBASE + 16*id. Handlers do not nest: after int_ack, the controller stays in
// service until reti. New edges that arrive in the meantime only accumulate
// as pending bits.
//
// Ports
//   clk         system clock, rising-edge active
//   reset       asynchronous, active-high reset
//   irq[3:0]    raw interrupt lines, bit 0 highest priority
//   mask_we     mask register write strobe
//   mask_in     new mask value (1 = line enabled)
//   int_ack     pulse: interrupt accepted by the control unit
//   reti        pulse: return-from-interrupt executed
//   int_req     registered interrupt request
//   vector      registered handler address, VBASE while int_req is low
//   in_service  registered: a handler is executing
//   pending     registered pending bits (masked and unmasked)
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter logic [9:0] VBASE = 10'h3C0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq,
    input  logic       mask_we,
    input  logic [3:0] mask_in,
    input  logic       int_ack,
    input  logic       reti,
    output logic       int_req,
    output logic [9:0] vector,
    output logic       in_service,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t      state_reg;
    logic [3:0]  irq_q_reg;
    logic [3:0]  pending_reg;
    logic [3:0]  mask_reg;
    logic [1:0]  id_reg;
    logic        int_req_reg;
    logic        in_service_reg;
    logic [9:0]  vector_reg;

    logic [3:0]  rise;
    logic [3:0]  eligible;
    logic [1:0]  sel_id;
    logic [3:0]  ack_clr;
    logic [3:0]  pending_next;

    // Rising-edge detect. Because irq_q_reg resets to zero, a line that is
    // already high when reset is released counts as one edge.
    assign rise     = irq & ~irq_q_reg;
    assign eligible = pending_reg & mask_reg;

    // Lowest-index eligible line wins.
    always_comb begin
        sel_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = 2'(i);
            end
        end
    end

    // The acknowledged line is cleared only on int_ack while in REQ. A new
    // edge on the same line in the same cycle is OR-ed in afterwards, so the
    // set takes priority over the clear.
    always_comb begin
        ack_clr = 4'b0000;
        if (state_reg == REQ && int_ack) begin
            ack_clr[id_reg] = 1'b1;
        end
    end

    assign pending_next = (pending_reg & ~ack_clr) | rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            irq_q_reg      <= 4'b0000;
            pending_reg    <= 4'b0000;
            mask_reg       <= 4'b0000;
            id_reg         <= 2'd0;
            int_req_reg    <= 1'b0;
            in_service_reg <= 1'b0;
            vector_reg     <= VBASE;
        end else begin
            irq_q_reg   <= irq;
            pending_reg <= pending_next;
            if (mask_we) begin
                mask_reg <= mask_in;
            end

            case (state_reg)
                IDLE: begin
                    // The selection is made from the registered pending and
                    // mask, so an edge seen at clock k requests at clock k+1.
                    if (eligible != 4'b0000) begin
                        state_reg   <= REQ;
                        id_reg      <= sel_id;
                        int_req_reg <= 1'b1;
                        vector_reg  <= VBASE + {4'b0000, sel_id, 4'b0000};
                    end
                end
                REQ: begin
                    // id, vector and int_req remain frozen until acknowledged.
                    if (int_ack) begin
                        state_reg      <= SERV;
                        int_req_reg    <= 1'b0;
                        in_service_reg <= 1'b1;
                        vector_reg     <= VBASE;
                    end
                end
                SERV: begin
                    // The controller always passes back through IDLE, so any
                    // request that is still pending is raised one clock after
                    // reti.
                    if (reti) begin
                        state_reg      <= IDLE;
                        in_service_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    int_req_reg    <= 1'b0;
                    in_service_reg <= 1'b0;
                    vector_reg     <= VBASE;
                end
            endcase
        end
    end

    assign int_req    = int_req_reg;
    assign vector     = vector_reg;
    assign in_service = in_service_reg;
    assign pending    = pending_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl - directed testbench for int_ctrl.
// Inputs change 1 ns after a rising edge. Outputs are checked at that point,
// after the edge has taken effect, against values worked out by hand.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       int_ack;
    logic       reti;
    logic       int_req;
    logic [9:0] vector;
    logic       in_service;
    logic [3:0] pending;

    int errors = 0;
    int checks = 0;

    int_ctrl #(.VBASE(10'h3C0)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .vector     (vector),
        .in_service (in_service),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic outs(input string tag, input logic r, input logic [9:0] v,
                        input logic s, input logic [3:0] p);
        check({tag, ".int_req"}, 16'(r == 1'b1 ? int_req : int_req), 16'(r));
        check({tag, ".vector"}, 16'(vector), 16'(v));
        check({tag, ".in_service"}, 16'(in_service), 16'(s));
        check({tag, ".pending"}, 16'(pending), 16'(p));
    endtask

    initial begin
        reset = 1'b1; irq = 4'b0; mask_we = 1'b0; mask_in = 4'b0;
        int_ack = 1'b0; reti = 1'b0;
        #1;
        outs("reset", 1'b0, 10'h3C0, 1'b0, 4'b0000);
        tick(); tick();
        reset = 1'b0;
        mask_we = 1'b1; mask_in = 4'b1111;
        tick();
        mask_we = 1'b0;

        // Single edge on irq[2]
        irq = 4'b0100; tick(); irq = 4'b0000;
        outs("p2_pend", 1'b0, 10'h3C0, 1'b0, 4'b0100);
        tick();
        outs("p2_req", 1'b1, 10'h3E0, 1'b0, 4'b0100);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        outs("p2_ack", 1'b0, 10'h3C0, 1'b1, 4'b0000);
        reti = 1'b1; tick(); reti = 1'b0;
        outs("p2_reti", 1'b0, 10'h3C0, 1'b0, 4'b0000);

        // Simultaneous edges on irq[3] and irq[1]
        irq = 4'b1010; tick(); irq = 4'b0000;
        outs("p31_pend", 1'b0, 10'h3C0, 1'b0, 4'b1010);
        tick();
        outs("p31_req1", 1'b1, 10'h3D0, 1'b0, 4'b1010);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        outs("p31_ack1", 1'b0, 10'h3C0, 1'b1, 4'b1000);
        tick();
        outs("p31_nonest", 1'b0, 10'h3C0, 1'b1, 4'b1000);
        reti = 1'b1; tick(); reti = 1'b0;
        outs("p31_reti", 1'b0, 10'h3C0, 1'b0, 4'b1000);
        tick();
        outs("p31_req3", 1'b1, 10'h3F0, 1'b0, 4'b1000);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        reti = 1'b1; tick(); reti = 1'b0;
        outs("p31_done", 1'b0, 10'h3C0, 1'b0, 4'b0000);

        // Frozen REQ: id 2 requested, irq[0] edge and a mask write arrive
        irq = 4'b0100; tick(); irq = 4'b0000;
        tick();
        outs("frz_req", 1'b1, 10'h3E0, 1'b0, 4'b0100);
        irq = 4'b0001; tick(); irq = 4'b0000;
        outs("frz_new0", 1'b1, 10'h3E0, 1'b0, 4'b0101);
        mask_we = 1'b1; mask_in = 4'b0000; tick();
        mask_in = 4'b1111; tick(); mask_we = 1'b0;
        outs("frz_mask", 1'b1, 10'h3E0, 1'b0, 4'b0101);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        outs("frz_ack", 1'b0, 10'h3C0, 1'b1, 4'b0001);
        reti = 1'b1; tick(); reti = 1'b0;
        tick();
        outs("frz_req0", 1'b1, 10'h3C0, 1'b0, 4'b0001);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        reti = 1'b1; tick(); reti = 1'b0;

        // Ack and a new edge on the same line in the same cycle: set wins
        irq = 4'b0010; tick(); irq = 4'b0000;
        tick();
        outs("sw_req", 1'b1, 10'h3D0, 1'b0, 4'b0010);
        int_ack = 1'b1; irq = 4'b0010; tick(); int_ack = 1'b0; irq = 4'b0000;
        outs("sw_ack", 1'b0, 10'h3C0, 1'b1, 4'b0010);
        reti = 1'b1; tick(); reti = 1'b0;
        tick();
        outs("sw_rereq", 1'b1, 10'h3D0, 1'b0, 4'b0010);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        reti = 1'b1; tick(); reti = 1'b0;

        // Stray int_ack in IDLE is ignored
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        outs("stray_ack", 1'b0, 10'h3C0, 1'b0, 4'b0000);

        // Masked pending, then unmask
        mask_we = 1'b1; mask_in = 4'b0000; tick(); mask_we = 1'b0;
        irq = 4'b0001; tick(); irq = 4'b0000;
        tick(); tick();
        outs("msk_hidden", 1'b0, 10'h3C0, 1'b0, 4'b0001);
        mask_we = 1'b1; mask_in = 4'b0001; tick(); mask_we = 1'b0;
        outs("msk_loaded", 1'b0, 10'h3C0, 1'b0, 4'b0001);
        tick();
        outs("msk_req", 1'b1, 10'h3C0, 1'b0, 4'b0001);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq = 4'b0100; tick(); irq = 4'b0000;
        outs("srv_pend", 1'b0, 10'h3C0, 1'b1, 4'b0100);

        // Asynchronous reset in SERV, between clock edges
        #2 reset = 1'b1;
        #1;
        outs("async_rst", 1'b0, 10'h3C0, 1'b0, 4'b0000);
        tick();
        reset = 1'b0;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        reti = 1'b1; tick(); reti = 1'b0;
        outs("post_rst", 1'b0, 10'h3C0, 1'b0, 4'b0000);

        // Line held high across reset release
        reset = 1'b1; irq = 4'b0010; tick();
        reset = 1'b0; mask_we = 1'b1; mask_in = 4'b0010;
        tick(); mask_we = 1'b0;
        outs("held_pend", 1'b0, 10'h3C0, 1'b0, 4'b0010);
        tick();
        outs("held_req", 1'b1, 10'h3D0, 1'b0, 4'b0010);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        outs("held_ack", 1'b0, 10'h3C0, 1'b1, 4'b0000);
        reti = 1'b1; tick(); reti = 1'b0;
        tick(); tick();
        outs("held_noreq", 1'b0, 10'h3C0, 1'b0, 4'b0000);
        irq = 4'b0000; tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
